// File: rtl/calc_sequencer_if.sv
// Keypad, ALU handshake and display bundle for the calculator sequencer.
interface calc_sequencer_if #(
  parameter int unsigned N_DIG = 4
);
  localparam int unsigned W = 4 * N_DIG;

  logic [3:0]   tecla;
  logic         tecla_valida;
  logic         alu_done;
  logic [W-1:0] alu_result;
  logic         alu_erro;
  logic [W-1:0] operando_a;
  logic [W-1:0] operando_b;
  logic [1:0]   operacao;
  logic         alu_start;
  logic [W-1:0] display;
  logic         erro;
  logic [2:0]   estado;
  logic         ocupado;

  // Environment side: keypad debouncer plus ALU/display datapath
  modport master (
    output tecla, tecla_valida, alu_done, alu_result, alu_erro,
    input  operando_a, operando_b, operacao, alu_start, display, erro, estado, ocupado
  );

  // Sequencer side
  modport slave (
    input  tecla, tecla_valida, alu_done, alu_result, alu_erro,
    output operando_a, operando_b, operacao, alu_start, display, erro, estado, ocupado
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator sequencer: assembles BCD operands/operator from keys and runs the ALU handshake.
// Optional ALU watchdog enabled by defining CALC_TIMEOUT_EN.
module calc_sequencer #(
  parameter int unsigned N_DIG       = 4,
  parameter int unsigned ALU_TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  calc_sequencer_if.slave bus
);
  localparam int unsigned W  = 4 * N_DIG;
  localparam int unsigned CW = $clog2(N_DIG + 1);

  localparam logic [2:0] ESPERA_A  = 3'b000;
  localparam logic [2:0] ENTRADA_A = 3'b001;
  localparam logic [2:0] ESPERA_B  = 3'b010;
  localparam logic [2:0] ENTRADA_B = 3'b011;
  localparam logic [2:0] CALCULA   = 3'b100;
  localparam logic [2:0] MOSTRA    = 3'b101;

  logic [2:0]    st_q, st_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic          start_q, start_d;
  logic          erro_q, erro_d;
  logic          clr;

`ifdef CALC_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(ALU_TIMEOUT + 1) > 8) ? $clog2(ALU_TIMEOUT + 1) : 8;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Key decode, qualified by the strobe
  logic       is_dig, is_op, is_eq, is_ce, is_ca;
  logic [1:0] key_op;
  assign is_dig = bus.tecla_valida && (bus.tecla <= 4'd9);
  assign is_op  = bus.tecla_valida && (bus.tecla inside {4'hA, 4'hB, 4'hC});
  assign is_eq  = bus.tecla_valida && (bus.tecla == 4'hD);
  assign is_ce  = bus.tecla_valida && (bus.tecla == 4'hE);
  assign is_ca  = bus.tecla_valida && (bus.tecla == 4'hF);
  assign key_op = 2'(bus.tecla - 4'hA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ESPERA_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      start_q <= 1'b0;
      erro_q  <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      st_q    <= st_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      start_q <= start_d;
      erro_q  <= erro_d;
`ifdef CALC_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    st_d    = st_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    start_d = 1'b0;
    erro_d  = erro_q;
    clr     = 1'b0;
`ifdef CALC_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (st_q)
      ESPERA_A: begin
        if (is_dig) begin
          a_d   = W'(bus.tecla);
          cnt_d = CW'(1);
          st_d  = ENTRADA_A;
        end else if (is_ca) begin
          clr = 1'b1;
        end
      end
      ENTRADA_A: begin
        if (is_dig) begin
          if (cnt_q != CW'(N_DIG)) begin
            a_d   = {a_q[W-5:0], bus.tecla};
            cnt_d = cnt_q + CW'(1);
          end
        end else if (is_op) begin
          op_d = key_op;
          st_d = ESPERA_B;
        end else if (is_ce) begin
          a_d   = '0;
          cnt_d = '0;
        end else if (is_ca) begin
          clr = 1'b1;
        end
      end
      ESPERA_B: begin
        if (is_op) begin
          op_d = key_op;
        end else if (is_dig) begin
          b_d   = W'(bus.tecla);
          cnt_d = CW'(1);
          st_d  = ENTRADA_B;
        end else if (is_ca) begin
          clr = 1'b1;
        end
      end
      ENTRADA_B: begin
        if (is_dig) begin
          if (cnt_q != CW'(N_DIG)) begin
            b_d   = {b_q[W-5:0], bus.tecla};
            cnt_d = cnt_q + CW'(1);
          end
        end else if (is_eq) begin
          st_d    = CALCULA;
          start_d = 1'b1;
`ifdef CALC_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else if (is_ce) begin
          b_d   = '0;
          cnt_d = '0;
        end else if (is_ca) begin
          clr = 1'b1;
        end
      end
      // Keys are dropped while the ALU works; a done coincident with the timeout wins
      CALCULA: begin
        if (bus.alu_done) begin
          res_d  = bus.alu_result;
          erro_d = bus.alu_erro;
          st_d   = MOSTRA;
`ifdef CALC_TIMEOUT_EN
        end else if (tmo_q == TW'(ALU_TIMEOUT - 1)) begin
          res_d  = '0;
          erro_d = 1'b1;
          st_d   = MOSTRA;
        end else begin
          tmo_d = tmo_q + TW'(1);
`endif
        end
      end
      MOSTRA: begin
        if (is_dig) begin
          erro_d = 1'b0;
          a_d    = W'(bus.tecla);
          cnt_d  = CW'(1);
          st_d   = ENTRADA_A;
        end else if (is_op && !erro_q) begin
          a_d  = res_q;
          op_d = key_op;
          st_d = ESPERA_B;
        end else if (is_ce || is_ca) begin
          clr = 1'b1;
        end
      end
      default: clr = 1'b1;
    endcase

    if (clr) begin
      st_d   = ESPERA_A;
      a_d    = '0;
      b_d    = '0;
      res_d  = '0;
      cnt_d  = '0;
      op_d   = '0;
      erro_d = 1'b0;
    end
  end

  always_comb begin
    case (st_q)
      ENTRADA_A, ESPERA_B: bus.display = a_q;
      ENTRADA_B, CALCULA:  bus.display = b_q;
      MOSTRA:              bus.display = erro_q ? '0 : res_q;
      default:             bus.display = '0;
    endcase
  end

  assign bus.operando_a = a_q;
  assign bus.operando_b = b_q;
  assign bus.operacao   = op_q;
  assign bus.alu_start  = start_q;
  assign bus.erro       = erro_q;
  assign bus.estado     = st_q;
  assign bus.ocupado    = (st_q == CALCULA);
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer; a stub ALU answers from the bench with fixed results.
module tb_calc_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   starts = 0;
  int   s0;

  calc_sequencer_if #(.N_DIG(4)) bus ();

  calc_sequencer #(.N_DIG(4), .ALU_TIMEOUT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.alu_start === 1'b1) starts++;

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.tecla        = k;
    bus.tecla_valida = 1'b1;
    @(negedge clk);
    bus.tecla_valida = 1'b0;
  endtask

  task automatic reply(input int dly, input logic [15:0] r, input logic e);
    repeat (dly) @(negedge clk);
    bus.alu_done   = 1'b1;
    bus.alu_result = r;
    bus.alu_erro   = e;
    @(negedge clk);
    bus.alu_done   = 1'b0;
    bus.alu_erro   = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (bus.estado !== 3'b000) begin n_fail++; $display("FAIL rst_estado got %b exp 000", bus.estado); end
    n_chk++; if (bus.operando_a !== 16'h0) begin n_fail++; $display("FAIL rst_a got %h exp 0000", bus.operando_a); end
    n_chk++; if (bus.operando_b !== 16'h0) begin n_fail++; $display("FAIL rst_b got %h exp 0000", bus.operando_b); end
    n_chk++; if ({bus.operacao, bus.alu_start, bus.erro, bus.ocupado} !== 5'b0) begin n_fail++; $display("FAIL rst_ctl got %b exp 00000", {bus.operacao, bus.alu_start, bus.erro, bus.ocupado}); end
    n_chk++; if (bus.display !== 16'h0) begin n_fail++; $display("FAIL rst_disp got %h exp 0000", bus.display); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    press(4'h1); press(4'h2);
    n_chk++; if (bus.display !== 16'h0012) begin n_fail++; $display("FAIL add_disp_a got %h exp 0012", bus.display); end
    n_chk++; if (bus.estado !== 3'b001) begin n_fail++; $display("FAIL add_st_a got %b exp 001", bus.estado); end
    press(4'hA);
    n_chk++; if (bus.operacao !== 2'b00 || bus.estado !== 3'b010) begin n_fail++; $display("FAIL add_op got %b/%b exp 00/010", bus.operacao, bus.estado); end
    press(4'h3);
    n_chk++; if (bus.display !== 16'h0003) begin n_fail++; $display("FAIL add_disp_b got %h exp 0003", bus.display); end
    s0 = starts;
    press(4'hD);
    n_chk++; if (bus.estado !== 3'b100 || bus.alu_start !== 1'b1 || bus.ocupado !== 1'b1) begin n_fail++; $display("FAIL add_calc got st=%b start=%b busy=%b exp 100/1/1", bus.estado, bus.alu_start, bus.ocupado); end
    reply(3, 16'h0015, 1'b0);
    n_chk++; if (bus.estado !== 3'b101 || bus.display !== 16'h0015) begin n_fail++; $display("FAIL add_result got st=%b disp=%h exp 101/0015", bus.estado, bus.display); end
    n_chk++; if (starts - s0 !== 1) begin n_fail++; $display("FAIL add_start_count got %0d exp 1", starts - s0); end
    n_chk++; if (bus.ocupado !== 1'b0) begin n_fail++; $display("FAIL add_busy_off got %b exp 0", bus.ocupado); end
  endtask

  task automatic test_digit_limit();
    press(4'hF);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
    n_chk++; if (bus.operando_a !== 16'h9876) begin n_fail++; $display("FAIL lim_a got %h exp 9876", bus.operando_a); end
    press(4'hE);
    n_chk++; if (bus.operando_a !== 16'h0 || bus.estado !== 3'b001) begin n_fail++; $display("FAIL lim_ce got %h/%b exp 0000/001", bus.operando_a, bus.estado); end
    press(4'h4);
    n_chk++; if (bus.operando_a !== 16'h0004) begin n_fail++; $display("FAIL lim_reload got %h exp 0004", bus.operando_a); end
  endtask

  task automatic test_operator_overwrite();
    press(4'hA); press(4'hC);
    n_chk++; if (bus.operacao !== 2'b10 || bus.estado !== 3'b010) begin n_fail++; $display("FAIL ovw_op got %b/%b exp 10/010", bus.operacao, bus.estado); end
    press(4'hF);
    n_chk++; if (bus.estado !== 3'b000 || bus.operando_a !== 16'h0 || bus.operando_b !== 16'h0 || bus.operacao !== 2'b00) begin n_fail++; $display("FAIL ovw_clr got st=%b a=%h b=%h op=%b exp 000/0000/0000/00", bus.estado, bus.operando_a, bus.operando_b, bus.operacao); end
    press(4'hA); press(4'hD);
    n_chk++; if (bus.estado !== 3'b000 || bus.display !== 16'h0) begin n_fail++; $display("FAIL idle_ignore got %b/%h exp 000/0000", bus.estado, bus.display); end
  endtask

  task automatic test_error();
    press(4'h5); press(4'hB); press(4'h2); press(4'hD);
    reply(1, 16'h1234, 1'b1);
    n_chk++; if (bus.erro !== 1'b1 || bus.display !== 16'h0 || bus.estado !== 3'b101) begin n_fail++; $display("FAIL err_show got erro=%b disp=%h st=%b exp 1/0000/101", bus.erro, bus.display, bus.estado); end
    press(4'hA);
    n_chk++; if (bus.estado !== 3'b101 || bus.operando_a !== 16'h0005 || bus.operacao !== 2'b01) begin n_fail++; $display("FAIL err_op_ignored got st=%b a=%h op=%b exp 101/0005/01", bus.estado, bus.operando_a, bus.operacao); end
    press(4'h7);
    n_chk++; if (bus.erro !== 1'b0 || bus.operando_a !== 16'h0007 || bus.estado !== 3'b001) begin n_fail++; $display("FAIL err_digit got erro=%b a=%h st=%b exp 0/0007/001", bus.erro, bus.operando_a, bus.estado); end
  endtask

  task automatic test_back_to_back();
    press(4'hF);
    press(4'h4); press(4'hC); press(4'h2); press(4'hD);
    reply(2, 16'h0008, 1'b0);
    n_chk++; if (bus.display !== 16'h0008) begin n_fail++; $display("FAIL chain_first got %h exp 0008", bus.display); end
    press(4'hC);
    n_chk++; if (bus.estado !== 3'b010 || bus.operando_a !== 16'h0008 || bus.operacao !== 2'b10) begin n_fail++; $display("FAIL chain_latch got st=%b a=%h op=%b exp 010/0008/10", bus.estado, bus.operando_a, bus.operacao); end
    press(4'h3);
    s0 = starts;
    press(4'hD);
    n_chk++; if (bus.alu_start !== 1'b1 || bus.operando_b !== 16'h0003) begin n_fail++; $display("FAIL chain_start got start=%b b=%h exp 1/0003", bus.alu_start, bus.operando_b); end
    reply(0, 16'h0024, 1'b0);
    n_chk++; if (bus.estado !== 3'b101 || bus.display !== 16'h0024) begin n_fail++; $display("FAIL chain_same_cycle got st=%b disp=%h exp 101/0024", bus.estado, bus.display); end
    n_chk++; if (starts - s0 !== 1) begin n_fail++; $display("FAIL chain_start_count got %0d exp 1", starts - s0); end
  endtask

  task automatic test_calcula_keys();
    press(4'hD);
    n_chk++; if (bus.estado !== 3'b101 || bus.display !== 16'h0024) begin n_fail++; $display("FAIL show_eq_ignored got %b/%h exp 101/0024", bus.estado, bus.display); end
    press(4'h1); press(4'hA); press(4'h2); press(4'hD);
    press(4'hF);
    n_chk++; if (bus.estado !== 3'b100 || bus.ocupado !== 1'b1 || bus.operando_b !== 16'h0002) begin n_fail++; $display("FAIL calc_drop_f got st=%b busy=%b b=%h exp 100/1/0002", bus.estado, bus.ocupado, bus.operando_b); end
    reply(1, 16'h0003, 1'b0);
    press(4'hE);
    n_chk++; if (bus.estado !== 3'b000 || bus.display !== 16'h0 || bus.operando_a !== 16'h0) begin n_fail++; $display("FAIL show_ce got st=%b disp=%h a=%h exp 000/0000/0000", bus.estado, bus.display, bus.operando_a); end
  endtask

`ifdef CALC_TIMEOUT_EN
  task automatic test_timeout();
    press(4'h1); press(4'hA); press(4'h1); press(4'hD);
    repeat (9) @(negedge clk);
    n_chk++; if (bus.estado !== 3'b100) begin n_fail++; $display("FAIL tmo_early got %b exp 100", bus.estado); end
    @(negedge clk);
    n_chk++; if (bus.estado !== 3'b101 || bus.erro !== 1'b1 || bus.display !== 16'h0) begin n_fail++; $display("FAIL tmo_fire got st=%b erro=%b disp=%h exp 101/1/0000", bus.estado, bus.erro, bus.display); end
    press(4'hF);
  endtask
`endif

  task automatic test_reset_abort();
    press(4'h3); press(4'hA); press(4'h4); press(4'hD);
    n_chk++; if (bus.estado !== 3'b100) begin n_fail++; $display("FAIL abort_enter got %b exp 100", bus.estado); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bus.estado !== 3'b000 || bus.operando_a !== 16'h0 || bus.operando_b !== 16'h0) begin n_fail++; $display("FAIL abort_regs got st=%b a=%h b=%h exp 000/0000/0000", bus.estado, bus.operando_a, bus.operando_b); end
    n_chk++; if ({bus.operacao, bus.alu_start, bus.erro, bus.ocupado} !== 5'b0 || bus.display !== 16'h0) begin n_fail++; $display("FAIL abort_ctl got %b disp=%h exp 00000/0000", {bus.operacao, bus.alu_start, bus.erro, bus.ocupado}, bus.display); end
    @(negedge clk);
    rst = 1'b0;
    reply(0, 16'h0007, 1'b0);
    n_chk++; if (bus.estado !== 3'b000 || bus.display !== 16'h0) begin n_fail++; $display("FAIL late_done got st=%b disp=%h exp 000/0000", bus.estado, bus.display); end
  endtask

  initial begin
    rst              = 1'b1;
    bus.tecla        = 4'h0;
    bus.tecla_valida = 1'b0;
    bus.alu_done     = 1'b0;
    bus.alu_result   = 16'h0;
    bus.alu_erro     = 1'b0;
    test_reset();
    test_basic_add();
    test_digit_limit();
    test_operator_overwrite();
    test_error();
    test_back_to_back();
    test_calcula_keys();
`ifdef CALC_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Top-level sequencing controller for the digital calculator. It accepts validated keypad codes and assembles two BCD operands plus an operator. It starts the arithmetic unit through a start/done handshake, captures the result and drives the display word. It sits between the keypad debouncer and the ALU/display datapath.

Parameters:
N_DIG, 4, number of BCD digits per operand/result (display width 4*N_DIG)
ALU_TIMEOUT, 255, max cycles waiting for alu_done (used only with CALC_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
tecla  in  4  key code: 0-9 digit, A add, B sub, C mul, D equals, E clear entry, F clear all
tecla_valida  in  1  one-cycle strobe, tecla valid
alu_done  in  1  ALU result valid (level or pulse)
alu_result  in  4*N_DIG  ALU result, BCD
alu_erro  in  1  ALU overflow/invalid, sampled with alu_done
operando_a  out  4*N_DIG  operand A, BCD, registered
operando_b  out  4*N_DIG  operand B, BCD, registered
operacao  out  2  00 add, 01 sub, 10 mul; registered
alu_start  out  1  one-cycle start pulse, registered
display  out  4*N_DIG  BCD word to 7-seg driver
erro  out  1  error flag, registered
estado  out  3  current FSM state
ocupado  out  1  high in CALCULA

Behaviour:
- Reset, asynchronous and active-high:
  - estado = ESPERA_A (000).
  - operando_a, operando_b, result register, digit counter, operacao, alu_start and erro all 0.
- States: ESPERA_A=000, ENTRADA_A=001, ESPERA_B=010, ENTRADA_B=011, CALCULA=100, MOSTRA=101. Codes 110/111 are illegal and go to ESPERA_A with all registers cleared.
- Keys act only in the cycle tecla_valida=1. One key is processed per strobe. Register updates are visible the next cycle.
- Digit append:
  - operand <= {operand[4*N_DIG-5:0], tecla}; cnt++.
  - If cnt==N_DIG the digit is ignored (no wrap, no shift).
  - The first digit into an operand loads {0..., tecla} and sets cnt=1.
- ESPERA_A:
  - digit: load A, go to ENTRADA_A.
  - F: clear all.
  - A-E: ignored.
- ENTRADA_A:
  - digit: append.
  - A/B/C: latch operacao, go to ESPERA_B.
  - D: ignored.
  - E: A=0, cnt=0, stay.
  - F: clear all, go to ESPERA_A.
- ESPERA_B:
  - A/B/C: overwrite operacao, stay.
  - digit: load B, go to ENTRADA_B.
  - D/E: ignored.
  - F: clear all, go to ESPERA_A.
- ENTRADA_B:
  - digit: append.
  - D: go to CALCULA.
  - A/B/C: ignored.
  - E: B=0, cnt=0, stay.
  - F: clear all, go to ESPERA_A.
- CALCULA:
  - alu_start=1 for exactly the first cycle in the state; ocupado=1 throughout.
  - Every key is dropped, including F.
  - On alu_done=1: capture alu_result into the result register, erro<=alu_erro, go to MOSTRA.
  - alu_done in the same cycle as alu_start is accepted.
- MOSTRA:
  - digit: clear erro, load A, go to ENTRADA_A.
  - A/B/C with erro=0: A<=result, latch operacao, go to ESPERA_B (chained operation). With erro=1 these keys are ignored.
  - D: ignored.
  - E/F: clear all, go to ESPERA_A.
- display, combinational mux of registered values:
  - ESPERA_A: 0.
  - ENTRADA_A, ESPERA_B: operando_a.
  - ENTRADA_B, CALCULA: operando_b.
  - MOSTRA: result, or 0 when erro=1.
- "Clear all" means A=B=result=0, cnt=0, operacao=00, erro=0.
- Reset mid-CALCULA aborts immediately. A late alu_done after reset is ignored because the FSM is in ESPERA_A.

Optional Feature:
CALC_TIMEOUT_EN.
- Defined: an 8+ bit counter is cleared on entry to CALCULA and counts each cycle. If it reaches ALU_TIMEOUT without alu_done, then erro<=1, result<=0, go to MOSTRA. alu_done on the same cycle as the timeout wins, with normal capture.
- Undefined: CALCULA waits for alu_done indefinitely; no counter logic is synthesized.

Test Plan:
- Keys 1,2,A,3,D; alu_done with result 0015 after 3 cycles. Required: operacao=00; alu_start pulses once; display shows 0012, then 0003, then 0015 in MOSTRA.
- N_DIG=4, keys 9,8,7,6,5. Required: operando_a=9876 (fifth digit ignored). Then E gives A=0000 and estado=001.
- In ESPERA_B: keys A then C. Required: operacao=10. Then F gives estado=000 and all operands 0.
- Keys 5,B,2,D; alu_done with alu_erro=1. Required: erro=1 and display=0000. A then ignored. Digit 7 gives erro=0, A=0007, estado=001.
- Chain: result 0008 in MOSTRA, then keys C,3,D. Required: operando_a=0008, operando_b=0003, operacao=10, second alu_start pulse.
- With CALC_TIMEOUT_EN and ALU_TIMEOUT=10, no alu_done. Required: estado=101 and erro=1 after 10 cycles. Separately, assert rst mid-CALCULA: all outputs return to 0 asynchronously.
